// File: rtl/fe_de_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer.
// fe_ready depends only on registered state, so de_ready has no path back to fetch.
module fe_de_skid_reg #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h00000013),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fe_valid,
  output logic              fe_ready,
  input  logic [XLEN-1:0]   fe_pc,
  input  logic [XLEN-1:0]   fe_pc_plus4,
  input  logic [XLEN-1:0]   fe_instr,
  input  logic              flush,
  output logic              de_valid,
  input  logic              de_ready,
  output logic [XLEN-1:0]   de_pc,
  output logic [XLEN-1:0]   de_pc_plus4,
  output logic [XLEN-1:0]   de_instr,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] skid_pc_p1, skid_pc_plus4_p1, skid_instr_p1;

  logic in_fire, out_fire;
  logic ld_main_fe, ld_main_skid, ld_skid, to_nop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fe_ready = (state != SKID);
  assign de_valid = (state != EMPTY);
  assign in_fire  = fe_valid & fe_ready;
  assign out_fire = de_valid & de_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_fe   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    to_nop       = 1'b0;
    if (flush) begin
      // Flush overrides both handshakes; any beat offered this cycle is dropped.
      state_nxt = EMPTY;
      to_nop    = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            ld_main_fe = 1'b1;
            state_nxt  = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            ld_main_fe = 1'b1;
          end else if (in_fire) begin
            ld_skid   = 1'b1;
            state_nxt = SKID;
          end else if (out_fire) begin
            to_nop    = 1'b1;
            state_nxt = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            ld_main_skid = 1'b1;
            state_nxt    = FULL;
          end
        end
        default: begin
          state_nxt = EMPTY;
          to_nop    = 1'b1;
        end
      endcase
    end
  end

  // Control state and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (de_valid && !de_ready)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

  // Main (decode-facing) entry; pc fields hold when the entry empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_pc       <= '0;
      de_pc_plus4 <= '0;
      de_instr    <= NOP_INSTR;
    end else if (ld_main_fe) begin
      de_pc       <= fe_pc;
      de_pc_plus4 <= fe_pc_plus4;
      de_instr    <= fe_instr;
    end else if (ld_main_skid) begin
      de_pc       <= skid_pc_p1;
      de_pc_plus4 <= skid_pc_plus4_p1;
      de_instr    <= skid_instr_p1;
    end else if (to_nop) begin
      de_instr    <= NOP_INSTR;
    end
  end

  // Skid entry: catches the beat accepted while decode stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc_p1       <= '0;
      skid_pc_plus4_p1 <= '0;
      skid_instr_p1    <= '0;
    end else if (ld_skid) begin
      skid_pc_p1       <= fe_pc;
      skid_pc_plus4_p1 <= fe_pc_plus4;
      skid_instr_p1    <= fe_instr;
    end
  end

endmodule

// File: tb/tb_fe_de_skid_reg.sv
// Bench for fe_de_skid_reg: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fe_de_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst;
  logic        fe_valid, fe_ready, flush, de_valid, de_ready;
  logic [31:0] fe_pc, fe_pc_plus4, fe_instr;
  logic [31:0] de_pc, de_pc_plus4, de_instr;
  logic [3:0]  stall_cycles;

  fe_de_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .fe_valid(fe_valid), .fe_ready(fe_ready),
    .fe_pc(fe_pc), .fe_pc_plus4(fe_pc_plus4), .fe_instr(fe_instr),
    .flush(flush),
    .de_valid(de_valid), .de_ready(de_ready),
    .de_pc(de_pc), .de_pc_plus4(de_pc_plus4), .de_instr(de_instr),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] last_pc, last_pc4;
  int          m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_pc  = 0;
    last_pc4 = 0;
    m_cnt    = 0;
  endtask

  // Reference behaviour: a FIFO of at most two beats, head visible to decode.
  task automatic model_update();
    bit    exp_valid, exp_ready, in_f, out_f;
    beat_t b;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() != 2);
    in_f  = fe_valid && exp_ready;
    out_f = exp_valid && de_ready;
    if (exp_valid && !de_ready && m_cnt < 15) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        b.pc = fe_pc; b.pc4 = fe_pc_plus4; b.instr = fe_instr;
        q.push_back(b);
      end
    end
    if (q.size() != 0) begin
      last_pc  = q[0].pc;
      last_pc4 = q[0].pc4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fe_ready"}, {31'd0, fe_ready}, {31'd0, q.size() != 2});
    chk({tag, ".de_valid"}, {31'd0, de_valid}, {31'd0, q.size() != 0});
    chk({tag, ".de_pc"}, de_pc, last_pc);
    chk({tag, ".de_pc_plus4"}, de_pc_plus4, last_pc4);
    chk({tag, ".de_instr"}, de_instr, (q.size() != 0) ? q[0].instr : NOP);
    chk({tag, ".stall"}, {28'd0, stall_cycles}, m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    fe_valid    = v;
    fe_pc       = pc;
    fe_pc_plus4 = pc + 32'd4;
    fe_instr    = instr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    rst = 1'b0;
  endtask

  logic [31:0] p_pc, p_pc4, p_instr;
  logic        p_stalled;
  logic [31:0] seq;

  initial begin
    rst = 1'b1; flush = 1'b0; de_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    do_reset();

    // Streaming at full rate.
    de_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h00500093); step("stream0"); chk("stream_pc0", de_pc, 32'h0);
    drive(1'b1, 32'h4, 32'h00A00113); step("stream1"); chk("stream_pc1", de_pc, 32'h4);
    drive(1'b1, 32'h8, 32'h00F00193); step("stream2"); chk("stream_pc2", de_pc, 32'h8);
    drive(1'b1, 32'hC, 32'h01400213); step("stream3"); chk("stream_pc3", de_pc, 32'hC);
    drive(1'b0, 32'h0, 32'h0);        step("stream_drain");
    chk("stream_stall", {28'd0, stall_cycles}, 32'd0);

    // Backpressure fills the skid entry.
    de_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h11111111); step("bp0");
    drive(1'b1, 32'h14, 32'h22222222); step("bp1");
    chk("bp_skid_ready", {31'd0, fe_ready}, 32'd0);
    drive(1'b1, 32'h18, 32'h33333333); step("bp2");
    step("bp3");
    chk("bp_hold_pc", de_pc, 32'h10);
    de_ready = 1'b1;
    step("bp_rel0"); chk("bp_out1", de_pc, 32'h14);
    step("bp_rel1"); chk("bp_out2", de_pc, 32'h18);
    drive(1'b0, 32'h0, 32'h0);
    step("bp_drain");
    chk("bp_stall", {28'd0, stall_cycles}, 32'd3);

    // Flush while in SKID with a beat offered.
    de_ready = 1'b0;
    drive(1'b1, 32'h30, 32'h44444444); step("fl0");
    drive(1'b1, 32'h34, 32'h55555555); step("fl1");
    drive(1'b1, 32'h20, 32'h66666666); flush = 1'b1; step("fl_flush");
    chk("fl_instr_nop", de_instr, NOP);
    chk("fl_ready", {31'd0, fe_ready}, 32'd1);
    chk("fl_pc_hold", de_pc, 32'h30);
    flush = 1'b0; de_ready = 1'b1;
    drive(1'b1, 32'h40, 32'h77777777); step("fl_next");
    chk("fl_next_pc", de_pc, 32'h40);
    drive(1'b0, 32'h0, 32'h0); step("fl_drain");

    // Asynchronous reset between edges while in SKID.
    de_ready = 1'b0;
    drive(1'b1, 32'h50, 32'h88888888); step("ar0");
    drive(1'b1, 32'h54, 32'h99999999); step("ar1");
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("ar_after");

    // Counter saturation.
    drive(1'b1, 32'h60, 32'hAAAAAAAA); step("sat_load");
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat_value", {28'd0, stall_cycles}, 32'd15);

    // Randomized traffic against the queue model.
    @(negedge clk);
    do_reset();
    seq = 32'h100;
    p_stalled = 1'b0;
    p_pc = de_pc; p_pc4 = de_pc_plus4; p_instr = de_instr;
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 9) < 7), seq, $urandom);
      de_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 99) < 3);
      p_stalled = de_valid && !de_ready && !flush;
      p_pc = de_pc; p_pc4 = de_pc_plus4; p_instr = de_instr;
      if (fe_valid && fe_ready) seq = seq + 32'd4;
      step("rnd");
      if (p_stalled) begin
        chk("rnd_stable_pc", de_pc, p_pc);
        chk("rnd_stable_pc4", de_pc_plus4, p_pc4);
        chk("rnd_stable_instr", de_instr, p_instr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_de_skid_reg.md
Name: fe_de_skid_reg

Overview:
- Fetch-to-decode pipeline register, directly downstream of the fetch-stage program counter and instruction memory read.
- Captures {pc, pc_plus4, instr} for each fetched instruction and presents it to decode through a valid/ready handshake.
- Uses a 2-entry skid buffer, so fetch_ready is a function of registered state only, with no combinational path from de_ready.
- Supports a flush from the branch/jump resolution logic and keeps a saturating decode-stall counter.

Parameters:
- XLEN, 32, width of pc, pc_plus4 and instr.
- NOP_INSTR, 32'h00000013, instruction word driven on de_instr while de_valid=0 (addi x0,x0,0).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- fe_valid  in  1  fetch presents a valid instruction.
- fe_ready  out  1  register can accept a beat; equals (state != SKID).
- fe_pc  in  XLEN  PC of the fetched instruction.
- fe_pc_plus4  in  XLEN  fe_pc+4, supplied by fetch.
- fe_instr  in  XLEN  fetched instruction word.
- flush  in  1  discard all held and incoming instructions.
- de_valid  out  1  decode output holds a valid instruction.
- de_ready  in  1  decode accepts this cycle.
- de_pc  out  XLEN  registered PC to decode.
- de_pc_plus4  out  XLEN  registered pc+4 to decode.
- de_instr  out  XLEN  registered instruction; NOP_INSTR when de_valid=0.
- stall_cycles  out  CNT_W  count of cycles with de_valid=1 and de_ready=0.

Behaviour:
- Definitions:
  - in_fire = fe_valid & fe_ready.
  - out_fire = de_valid & de_ready.
- Reset (async, while rst=1):
  - state=EMPTY, de_valid=0, de_pc=0, de_pc_plus4=0, de_instr=NOP_INSTR.
  - Skid entry cleared to 0; stall_cycles=0.
  - fe_ready=1 during and after reset.
  - A reset asserted mid-transfer drops all held beats.
- States: EMPTY (no entries), FULL (main entry valid), SKID (main and skid entries valid). de_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: in_fire -> load main from fe_*, go to FULL. Otherwise hold.
  - FULL, in_fire & out_fire -> load main from fe_*, stay FULL.
  - FULL, in_fire & !out_fire -> load skid from fe_*, go to SKID.
  - FULL, !in_fire & out_fire -> go to EMPTY; de_instr<=NOP_INSTR, de_pc and de_pc_plus4 hold.
  - FULL, neither -> hold.
  - SKID: fe_ready=0, so in_fire is impossible.
  - SKID, out_fire -> main<=skid, go to FULL.
  - SKID, !out_fire -> hold.
- Flush:
  - Highest priority, above in_fire and out_fire.
  - Next state=EMPTY, de_valid=0, de_instr=NOP_INSTR; de_pc and de_pc_plus4 hold their values.
  - A beat presented on fe_* in the flush cycle is dropped even if fe_ready=1.
  - An out_fire in the flush cycle still counts as consumed by decode.
- Latency and ordering:
  - A beat accepted in cycle N appears on de_* in cycle N+1 when the register was EMPTY, or FULL with out_fire.
  - Ordering is strictly FIFO.
  - No beat is duplicated or lost except by flush or reset.
- Stability: while de_valid=1 and de_ready=0, all de_* outputs hold constant.
- stall_cycles:
  - Increments by 1 each cycle with de_valid & !de_ready, flush included.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- Pure registers only; no combinational path from fe_* or de_ready to any output.

Test Plan:
- Streaming: reset, then de_ready=1 and fe_valid=1 with pc 0x0,0x4,0x8,0xC, instr 0x00500093,0x00A00113,... -> de_valid rises the cycle after the first beat; de_pc sequence 0x0,0x4,0x8,0xC in consecutive cycles; fe_ready stays 1; stall_cycles=0.
- Backpressure into skid: beats pc 0x10,0x14,0x18 offered while de_ready=0 -> 0x10 held on de_*, 0x14 captured in skid, fe_ready=0, 0x18 not accepted. Release de_ready -> outputs 0x10,0x14,0x18 in order; stall_cycles equals the stall cycle count (e.g. 3).
- Flush in SKID with fe_valid=1 (pc 0x20): next cycle de_valid=0, de_instr=0x00000013, fe_ready=1; 0x20 never appears. Beat pc 0x40 offered after the flush appears next.
- Async reset mid-operation: assert rst between clock edges while in SKID -> de_valid=0, de_pc=0, de_instr=0x00000013, fe_ready=1 immediately, without waiting for a clock edge; stall_cycles=0.
- Counter saturation (CNT_W=4): hold de_valid=1 with de_ready=0 for 20 cycles -> stall_cycles reaches 15 and stays 15.
- Random valid/ready/flush for 10k cycles against a queue model -> no loss, duplication or reordering outside flush; de_* stable while stalled.
